// File: rtl/reaction_timer_core.sv
// Reaction timer game core: mode selection, random pre-start wait, timed
// count-up run, false-start detection and best-score tracking.
module reaction_timer_core #(
  parameter int NUM_MODES  = 4,
  parameter int BASE_TICKS = 100000,
  parameter int WAIT_TICKS = 5000000,
  parameter int NUM_W      = 14,
  parameter int MAX_COUNT  = 9999
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         btn_up,
  input  logic                         btn_down,
  input  logic                         btn_start,
  input  logic                         btn_hit,
  output logic [2:0]                   state,
  output logic [$clog2(NUM_MODES)-1:0] mode,
  output logic                         go,
  output logic [NUM_W-1:0]             count,
  output logic [NUM_W-1:0]             best,
  output logic                         false_start,
  output logic                         new_best
);

  localparam int MW = $clog2(NUM_MODES);
  localparam int TW = (BASE_TICKS > 1) ? $clog2(BASE_TICKS) : 1;
  localparam int WW = $clog2(16 * WAIT_TICKS);

  localparam logic [2:0] S_SELECT = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_FOUL   = 3'd4;

  localparam logic [MW-1:0]    MODE_MAX  = MW'(NUM_MODES - 1);
  localparam logic [MW-1:0]    MODE_RST  = MW'(1);
  localparam logic [NUM_W-1:0] COUNT_MAX = NUM_W'(MAX_COUNT);

  logic          up_q, down_q, start_q, hit_q;
  logic          up_e, down_e, start_e, hit_e;
  logic [15:0]   lfsr;
  logic          lfsr_fb;
  logic [TW-1:0] tick_cnt;
  logic [WW-1:0] wait_cnt;
  logic [31:0]   period_full;
  logic [TW-1:0] period_last;
  logic [31:0]   wait_full;
  logic [WW-1:0] wait_load;
  logic [NUM_W-1:0] count_next;

  assign up_e    = btn_up    & ~up_q;
  assign down_e  = btn_down  & ~down_q;
  assign start_e = btn_start & ~start_q;
  assign hit_e   = btn_hit   & ~hit_q;

  // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_comb begin
    period_full = 32'(BASE_TICKS) >> mode;
    if (period_full == 32'd0) period_full = 32'd1;
  end

  assign period_last = TW'(period_full - 32'd1);
  assign wait_full   = (32'(lfsr[3:0]) + 32'd1) * 32'(WAIT_TICKS) - 32'd1;
  assign wait_load   = WW'(wait_full);
  assign count_next  = count + NUM_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      start_q     <= 1'b0;
      hit_q       <= 1'b0;
      lfsr        <= 16'hACE1;
      state       <= S_SELECT;
      mode        <= MODE_RST;
      go          <= 1'b0;
      count       <= '0;
      best        <= COUNT_MAX;
      false_start <= 1'b0;
      new_best    <= 1'b0;
      tick_cnt    <= '0;
      wait_cnt    <= '0;
    end else begin
      up_q     <= btn_up;
      down_q   <= btn_down;
      start_q  <= btn_start;
      hit_q    <= btn_hit;
      lfsr     <= {lfsr[14:0], lfsr_fb};
      new_best <= 1'b0;
      case (state)
        S_SELECT: begin
          if (start_e) begin
            state    <= S_WAIT;
            wait_cnt <= wait_load;
          end else if (up_e && !down_e) begin
            if (mode != MODE_MAX) mode <= mode + MW'(1);
          end else if (down_e && !up_e) begin
            if (mode != '0) mode <= mode - MW'(1);
          end
        end
        S_WAIT: begin
          // a hit on the expiry cycle still counts as a false start
          if (hit_e) begin
            state       <= S_FOUL;
            false_start <= 1'b1;
          end else if (wait_cnt == '0) begin
            state    <= S_RUN;
            go       <= 1'b1;
            count    <= '0;
            tick_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt - WW'(1);
          end
        end
        S_RUN: begin
          if (hit_e) begin
            state <= S_DONE;
            go    <= 1'b0;
            if (count < best) begin
              best     <= count;
              new_best <= 1'b1;
            end
          end else if (tick_cnt == period_last) begin
            tick_cnt <= '0;
            if (count_next >= COUNT_MAX) begin
              count <= COUNT_MAX;
              state <= S_DONE;
              go    <= 1'b0;
            end else begin
              count <= count_next;
            end
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        S_DONE, S_FOUL: begin
          if (start_e) begin
            state       <= S_SELECT;
            count       <= '0;
            false_start <= 1'b0;
          end
        end
        default: begin
          state <= S_SELECT;
          go    <= 1'b0;
        end
      endcase
    end
  end

endmodule
